// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU memory stage and one device master.
// One access per IDLE -> ACC -> RESP pass; a CPU-grant counter bounds device starvation.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [2:0]  i_cpu_op,
    output logic        o_cpu_ack,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_dev_req,
    input  logic        i_dev_we,
    input  logic [31:0] i_dev_addr,
    input  logic [31:0] i_dev_wdata,
    input  logic [2:0]  i_dev_op,
    output logic        o_dev_ack,
    output logic [31:0] o_dev_rdata,
    output logic [31:0] o_dmemaddr,
    output logic [31:0] o_dmemdatain,
    output logic [2:0]  o_dmemop,
    output logic        o_dmemwe,
    output logic        o_dmemrdclk,
    output logic        o_dmemwrclk,
    input  logic [31:0] i_dmemdataout
);
    // state  | meaning
    // IDLE   | arbitrate between pending requests
    // ACC    | dmem port driven from the granted master, write commits on negedge
    // RESP   | granted master acked, read data forwarded from dmem
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic G_CPU = 1'b0;
    localparam logic G_DEV = 1'b1;

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]    r_state;
    logic          r_gnt;
    logic [CW-1:0] r_starve_cnt;
    logic          r_we;

    logic          w_pick_dev;
    logic          w_sel_we;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [2:0]    w_sel_op;
    logic          w_in_acc;
    logic          w_in_resp;

    assign w_pick_dev  = i_dev_req & (~i_cpu_req | (r_starve_cnt == LIMIT));
    assign w_sel_we    = (r_gnt == G_DEV) ? i_dev_we    : i_cpu_we;
    assign w_sel_addr  = (r_gnt == G_DEV) ? i_dev_addr  : i_cpu_addr;
    assign w_sel_wdata = (r_gnt == G_DEV) ? i_dev_wdata : i_cpu_wdata;
    assign w_sel_op    = (r_gnt == G_DEV) ? i_dev_op    : i_cpu_op;
    assign w_in_acc    = (r_state == S_ACC);
    assign w_in_resp   = (r_state == S_RESP);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_gnt        <= G_CPU;
            r_starve_cnt <= '0;
            r_we         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req | i_dev_req) begin
                        r_gnt   <= w_pick_dev;
                        r_state <= S_ACC;
                        // only a CPU win over a waiting device counts toward starvation
                        if (!w_pick_dev && i_dev_req)
                            r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt
                                                                    : r_starve_cnt + 1'b1;
                        else
                            r_starve_cnt <= '0;
                    end
                end
                S_ACC: begin
                    r_we    <= w_sel_we;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_dmemaddr   = 32'd0;
        o_dmemdatain = 32'd0;
        o_dmemop     = 3'd0;
        o_dmemwe     = 1'b0;
        if (w_in_acc) begin
            o_dmemaddr   = w_sel_addr;
            o_dmemdatain = w_sel_wdata;
            o_dmemop     = w_sel_op;
            o_dmemwe     = w_sel_we;
        end
    end

    assign o_cpu_ack   = w_in_resp & (r_gnt == G_CPU);
    assign o_dev_ack   = w_in_resp & (r_gnt == G_DEV);
    assign o_cpu_rdata = (o_cpu_ack && !r_we) ? i_dmemdataout : 32'd0;
    assign o_dev_rdata = (o_dev_ack && !r_we) ? i_dmemdataout : 32'd0;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;

    assign o_dmemrdclk = i_clock;
    assign o_dmemwrclk = ~i_clock;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses against a small synchronous-read memory model,
// with ack data checked by a scoreboard monitor decoupled from the stimulus.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]  cpu_op = '0;
    logic        cpu_ack, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dev_req = 1'b0, dev_we = 1'b0;
    logic [31:0] dev_addr = '0, dev_wdata = '0;
    logic [2:0]  dev_op = '0;
    logic        dev_ack;
    logic [31:0] dev_rdata;
    logic [31:0] dmemaddr, dmemdatain, dmemdataout;
    logic [2:0]  dmemop;
    logic        dmemwe, dmemrdclk, dmemwrclk;

    logic [31:0] mem [0:255];
    logic [31:0] cpu_q[$];
    logic [31:0] dev_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          cpu_ack_total = 0;
    int          dev_ack_total = 0;
    int          last_cpu_ack_cyc = 0;
    int          last_dev_ack_cyc = 0;
    int          cpu_acks_at_dev = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_op(cpu_op),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dev_req(dev_req), .i_dev_we(dev_we), .i_dev_addr(dev_addr),
        .i_dev_wdata(dev_wdata), .i_dev_op(dev_op),
        .o_dev_ack(dev_ack), .o_dev_rdata(dev_rdata),
        .o_dmemaddr(dmemaddr), .o_dmemdatain(dmemdatain), .o_dmemop(dmemop),
        .o_dmemwe(dmemwe), .o_dmemrdclk(dmemrdclk), .o_dmemwrclk(dmemwrclk),
        .i_dmemdataout(dmemdataout)
    );

    always @(posedge dmemrdclk) dmemdataout <= mem[dmemaddr[9:2]];
    always @(posedge dmemwrclk) if (dmemwe) mem[dmemaddr[9:2]] <= dmemdatain;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_ack && dev_ack) fail_now("ack_overlap");
            if (cpu_ack) begin
                if (cpu_q.size() == 0) fail_now("cpu_unexpected_ack");
                else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                cpu_ack_total++;
                last_cpu_ack_cyc = cyc;
            end
            if (dev_ack) begin
                if (dev_q.size() == 0) fail_now("dev_unexpected_ack");
                else chk("dev_rdata", dev_rdata, dev_q.pop_front());
                dev_ack_total++;
                last_dev_ack_cyc = cyc;
                cpu_acks_at_dev = cpu_ack_total;
            end
        end
    end

    // n back-to-back accesses from one master; req held high between them
    task automatic access(input bit dev, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] op,
                          input logic [31:0] exp_rdata, input int n);
        int k;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (dev) begin
                dev_q.push_back(exp_rdata);
                dev_we = we; dev_addr = addr; dev_wdata = wdata; dev_op = op; dev_req = 1'b1;
            end else begin
                cpu_q.push_back(exp_rdata);
                cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_op = op; cpu_req = 1'b1;
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(dev ? dev_ack : cpu_ack) && k < 40);
            if (!(dev ? dev_ack : cpu_ack))
                fail_now(dev ? "dev_ack_timeout" : "cpu_ack_timeout");
            @(posedge clk); #1;
        end
        if (dev) dev_req = 1'b0;
        else     cpu_req = 1'b0;
    endtask

    initial begin
        int we_cycles;
        int cpu_before;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[64] = 32'hDEADBEEF;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_dev_ack", {31'd0, dev_ack}, 32'd0);
        chk("rst_dmemwe", {31'd0, dmemwe}, 32'd0);
        chk("rst_dmemaddr", dmemaddr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // CPU read alone, cycle by cycle
        @(posedge clk); #1;
        cpu_q.push_back(32'hDEADBEEF);
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_op = 3'b010; cpu_req = 1'b1;
        @(negedge clk);
        chk("rd_stall_idle", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        chk("rd_acc_addr", dmemaddr, 32'h100);
        chk("rd_acc_we", {31'd0, dmemwe}, 32'd0);
        chk("rd_stall_acc", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        chk("rd_resp_ack", {31'd0, cpu_ack}, 32'd1);
        chk("rd_resp_stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_after_addr", dmemaddr, 32'd0);

        // device write: dmemwe exactly one cycle with granted fields, no CPU ack
        cpu_before = cpu_ack_total;
        we_cycles = 0;
        fork
            access(1'b1, 1'b1, 32'h20, 32'h1234, 3'b010, 32'd0, 1);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (dmemwe) begin
                    we_cycles++;
                    chk("devwr_addr", dmemaddr, 32'h20);
                    chk("devwr_data", dmemdatain, 32'h1234);
                    chk("devwr_op", {29'd0, dmemop}, 32'd2);
                end
            end
        join
        chk("devwr_we_cycles", we_cycles, 32'd1);
        chk("devwr_no_cpu_ack", cpu_ack_total - cpu_before, 32'd0);
        chk("devwr_mem", mem[8], 32'h1234);
        access(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 32'h1234, 1);

        // both request with counter at 0: CPU first, device 3 cycles later
        fork
            access(1'b0, 1'b0, 32'h100, 32'd0, 3'b010, 32'hDEADBEEF, 1);
            access(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 32'h1234, 1);
        join
        chk("both_dev_after_cpu", last_dev_ack_cyc - last_cpu_ack_cyc, 32'd3);

        // starvation: device waits behind exactly 4 CPU grants
        cpu_before = cpu_ack_total;
        fork
            access(1'b0, 1'b0, 32'h100, 32'd0, 3'b010, 32'hDEADBEEF, 6);
            access(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 32'h1234, 1);
        join
        chk("starve_cpu_grants", cpu_acks_at_dev - cpu_before, 32'd4);
        chk("starve_total_cpu", cpu_ack_total - cpu_before, 32'd6);

        // counter back at 0: simultaneous requests give CPU the first grant again
        fork
            access(1'b0, 1'b0, 32'h100, 32'd0, 3'b010, 32'hDEADBEEF, 1);
            access(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, 32'h1234, 1);
        join
        chk("cnt_clr_dev_after_cpu", last_dev_ack_cyc - last_cpu_ack_cyc, 32'd3);

        // reset during ACC of a CPU write aborts it
        cpu_before = cpu_ack_total;
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; cpu_op = 3'b010; cpu_req = 1'b1;
        @(posedge clk); #2;
        chk("abort_we_in_acc", {31'd0, dmemwe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_dropped", {31'd0, dmemwe}, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_mem", mem[16], 32'd0);
        chk("abort_no_ack", cpu_ack_total - cpu_before, 32'd0);
        chk("abort_idle_addr", dmemaddr, 32'd0);
        access(1'b0, 1'b0, 32'h100, 32'd0, 3'b010, 32'hDEADBEEF, 1);

        // idle: nothing moves for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_we", {31'd0, dmemwe}, 32'd0);
            chk("idle_acks", {30'd0, cpu_ack, dev_ack}, 32'd0);
            chk("idle_addr", dmemaddr, 32'd0);
        end

        chk("sb_cpu_empty", cpu_q.size(), 32'd0);
        chk("sb_dev_empty", dev_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
